// File: rtl/intc_prio_pkg.sv
// Shared types and helpers for the intc_prio priority interrupt controller.
// The level-sensitive build option is selected by the INTC_LEVEL_EN macro.
package intc_pkg;

  localparam int INTC_N = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTER = 2'd1,
    ST_EXIT  = 2'd2
  } state_e;

  // One-hot of the most significant set bit; zero in, zero out.
  function automatic logic [INTC_N-1:0] msb_onehot(input logic [INTC_N-1:0] v);
    // NOTE: blocking assignments inside a function; later (higher) bits overwrite earlier ones.
    msb_onehot = '0;
    for (int i = 0; i < INTC_N; i++) begin
      if (v[i]) begin
        msb_onehot    = '0;
        msb_onehot[i] = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/intc_prio_if.sv
// Request/acknowledge bundle between the interrupt controller and the control unit.
interface intc_prio_if;
  import intc_pkg::*;

  logic [INTC_N-1:0] irq;
  logic              mask_we;
  logic [INTC_N-1:0] mask_d;
  logic [INTC_N-1:0] s_calli;
  logic [INTC_N-1:0] s_reti;
  logic [INTC_N-1:0] max_bit_s;
  logic [INTC_N-1:0] max_bit_a;
  logic [INTC_N-1:0] mask_q;
  logic [INTC_N-1:0] pend_q;

  modport master (
    output irq, mask_we, mask_d, s_calli, s_reti,
    input  max_bit_s, max_bit_a, mask_q, pend_q
  );

  modport slave (
    input  irq, mask_we, mask_d, s_calli, s_reti,
    output max_bit_s, max_bit_a, mask_q, pend_q
  );

endinterface

// File: rtl/intc_prio_sync.sv
// Multi-stage synchroniser for the raw irq lines plus a rising-edge detector
// on the synchronised level.
module intc_sync
  import intc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INTC_N-1:0] irq,
  output logic [INTC_N-1:0] lvl,
  output logic [INTC_N-1:0] rise
);

  // chain[0] samples the raw line; chain[SYNC_STAGES-1] is the safe level.
  logic [SYNC_STAGES-1:0][INTC_N-1:0] chain;
  logic [INTC_N-1:0]                  prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the value from before this edge.
      chain <= {chain[SYNC_STAGES-2:0], irq};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign lvl  = chain[SYNC_STAGES-1];
  assign rise = lvl & ~prev;

endmodule

// File: rtl/intc_prio.sv
// 8-source priority interrupt controller: pending/in-service/mask registers,
// hold-off FSM and one-hot arbitration. Define INTC_LEVEL_EN for level-sensitive sources.
module intc_prio
  import intc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 1
) (
  input logic        clk,
  input logic        reset,
  intc_prio_if.slave bus
);

  localparam logic [1:0] CNT_LOAD = 2'(HOLDOFF - 1);

  logic [INTC_N-1:0] lvl;
  logic [INTC_N-1:0] rise;
  logic [INTC_N-1:0] pend;
  logic [INTC_N-1:0] isr;
  logic [INTC_N-1:0] mask;
  logic [INTC_N-1:0] cand;
  logic [INTC_N-1:0] act;
  logic [INTC_N-1:0] max_s;
  state_e            state, state_nx;
  logic [1:0]        cnt, cnt_nx;

  intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .irq   (bus.irq),
    .lvl   (lvl),
    .rise  (rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
      isr  <= '0;
      mask <= '0;
    end else begin
`ifdef INTC_LEVEL_EN
      pend <= lvl;
`else
      // A fresh edge wins over an acknowledge of the same source.
      pend <= rise | (pend & ~bus.s_calli);
`endif
      isr <= (isr & ~bus.s_reti) | bus.s_calli;
      if (bus.mask_we) mask <= bus.mask_d;
    end
  end

`ifdef INTC_LEVEL_EN
  logic unused_rise;
  assign unused_rise = ^rise;
`else
  logic unused_lvl;
  assign unused_lvl = ^lvl;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign cand = msb_onehot(pend & mask);
  assign act  = msb_onehot(isr);

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_nx = state;
    cnt_nx   = cnt;
    max_s    = act;
    // Any calli/reti restarts the hold-off, whatever the current state.
    if (bus.s_calli != '0) begin
      state_nx = ST_ENTER;
      cnt_nx   = CNT_LOAD;
    end else if (bus.s_reti != '0) begin
      state_nx = ST_EXIT;
      cnt_nx   = CNT_LOAD;
    end else if (state != ST_RUN) begin
      if (cnt == 2'd0) state_nx = ST_RUN;
      else             cnt_nx   = cnt - 2'd1;
    end
    // Only a strictly higher request may preempt, and never during hold-off.
    if (state == ST_RUN && cand > act) max_s = cand;
  end

  assign bus.max_bit_s = max_s;
  assign bus.max_bit_a = act;
  assign bus.mask_q    = mask;
  assign bus.pend_q    = pend;

endmodule

// File: tb/tb_intc_prio.sv
// Self-checking bench for intc_prio: vector table plus hand-written multi-cycle
// sequences, with expectations queued on a scoreboard and compared at each sample point.
module tb_intc_prio;
  import intc_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int HOLDOFF     = 1;

  logic clk = 1'b0;
  logic reset;
  intc_prio_if bus ();

  intc_prio #(.SYNC_STAGES(SYNC_STAGES), .HOLDOFF(HOLDOFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] pend;
    logic [7:0] s;
    logic [7:0] a;
    logic [7:0] mask;
  } exp_t;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] irq;
    logic [7:0] calli;
    logic [7:0] pend;
    logic [7:0] s;
    logic [7:0] a;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [7:0] pend, input logic [7:0] s,
                            input logic [7:0] a, input logic [7:0] mask);
    exp_t e;
    e.name = name; e.pend = pend; e.s = s; e.a = a; e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    check({e.name, ".pend"}, bus.pend_q, e.pend);
    check({e.name, ".max_s"}, bus.max_bit_s, e.s);
    check({e.name, ".max_a"}, bus.max_bit_a, e.a);
    check({e.name, ".mask"}, bus.mask_q, e.mask);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic idle_inputs();
    bus.irq = '0; bus.mask_we = 1'b0; bus.mask_d = '0;
    bus.s_calli = '0; bus.s_reti = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic write_mask(input logic [7:0] m);
    bus.mask_we = 1'b1;
    bus.mask_d  = m;
    step();
    bus.mask_we = 1'b0;
  endtask

  // Leaves the bench at the first sample point where the edge is in pend.
  task automatic pulse_irq(input logic [7:0] v);
    bus.irq = v;
    step();
    bus.irq = '0;
    cycles(SYNC_STAGES);
  endtask

  // One-cycle calli/reti strobe; returns inside the hold-off window.
  task automatic strobe(input logic [7:0] c, input logic [7:0] r);
    bus.s_calli = c;
    bus.s_reti  = r;
    step();
    bus.s_calli = '0;
    bus.s_reti  = '0;
  endtask

  initial begin
    //          mask   irq    calli  pend   max_s  max_a
    vecs[0] = '{8'hFF, 8'h04, 8'h00, 8'h04, 8'h04, 8'h00};
    vecs[1] = '{8'hFF, 8'h24, 8'h00, 8'h24, 8'h20, 8'h00};
    vecs[2] = '{8'hDF, 8'h20, 8'h00, 8'h20, 8'h00, 8'h00};
    vecs[3] = '{8'hFF, 8'h24, 8'h20, 8'h04, 8'h20, 8'h20};
    vecs[4] = '{8'hFF, 8'h24, 8'h04, 8'h20, 8'h20, 8'h04};
    vecs[5] = '{8'hFF, 8'h80, 8'h01, 8'h80, 8'h80, 8'h01};
    vecs[6] = '{8'h7F, 8'h81, 8'h00, 8'h81, 8'h01, 8'h00};
    vecs[7] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[8] = '{8'hFF, 8'h10, 8'h10, 8'h00, 8'h10, 8'h10};
    vecs[9] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};

    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    expect_out("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    compare_out();
    reset = 1'b0;
    step();

`ifndef INTC_LEVEL_EN
    for (int i = 0; i < 10; i++) begin
      do_reset();
      write_mask(vecs[i].mask);
      expect_out($sformatf("vec%0d", i), vecs[i].pend, vecs[i].s, vecs[i].a, vecs[i].mask);
      pulse_irq(vecs[i].irq);
      if (vecs[i].calli != 8'h00) begin
        strobe(vecs[i].calli, 8'h00);
        cycles(HOLDOFF);
      end
      compare_out();
    end

    // Hold-off suppresses preemption, nesting, and a lower request staying put.
    do_reset();
    write_mask(8'hFF);
    pulse_irq(8'h24);
    expect_out("hold.pend", 8'h24, 8'h20, 8'h00, 8'hFF); compare_out();
    expect_out("hold.enter", 8'h20, 8'h04, 8'h04, 8'hFF);
    strobe(8'h04, 8'h00); compare_out();
    cycles(HOLDOFF);
    expect_out("hold.run", 8'h20, 8'h20, 8'h04, 8'hFF); compare_out();
    expect_out("hold.nest", 8'h00, 8'h20, 8'h20, 8'hFF);
    strobe(8'h20, 8'h00); compare_out();
    cycles(HOLDOFF);
    pulse_irq(8'h02);
    expect_out("hold.low", 8'h02, 8'h20, 8'h20, 8'hFF); compare_out();
    expect_out("hold.exit", 8'h02, 8'h04, 8'h04, 8'hFF);
    strobe(8'h00, 8'h20); compare_out();
    cycles(HOLDOFF);
    expect_out("hold.after", 8'h02, 8'h04, 8'h04, 8'hFF); compare_out();

    // Same-cycle calli/reti on one bit, and same-cycle edge/calli on one bit.
    do_reset();
    write_mask(8'hFF);
    pulse_irq(8'h80);
    expect_out("same.calli", 8'h80, 8'h08, 8'h08, 8'hFF);
    strobe(8'h08, 8'h00); compare_out();
    cycles(HOLDOFF);
    expect_out("same.run", 8'h80, 8'h80, 8'h08, 8'hFF); compare_out();
    expect_out("same.both", 8'h80, 8'h08, 8'h08, 8'hFF);
    strobe(8'h08, 8'h08); compare_out();
    cycles(HOLDOFF);
    expect_out("same.run2", 8'h80, 8'h80, 8'h08, 8'hFF); compare_out();
    bus.irq = 8'h08;
    step();
    bus.irq = '0;
    cycles(SYNC_STAGES - 1);
    expect_out("same.edge", 8'h88, 8'h08, 8'h08, 8'hFF);
    strobe(8'h08, 8'h00); compare_out();
    cycles(HOLDOFF);
    expect_out("same.run3", 8'h88, 8'h80, 8'h08, 8'hFF); compare_out();

    // Masked source latches but does not arbitrate until unmasked.
    do_reset();
    write_mask(8'hDF);
    pulse_irq(8'h20);
    expect_out("mask.off", 8'h20, 8'h00, 8'h00, 8'hDF); compare_out();
    expect_out("mask.on", 8'h20, 8'h20, 8'h00, 8'hFF);
    write_mask(8'hFF); compare_out();

    // Asynchronous reset in mid-service, then normal resumption.
    do_reset();
    write_mask(8'hFF);
    strobe(8'h20, 8'h00); cycles(HOLDOFF);
    strobe(8'h04, 8'h00); cycles(HOLDOFF);
    pulse_irq(8'h81);
    expect_out("rst.pre", 8'h81, 8'h80, 8'h20, 8'hFF); compare_out();
    #2 reset = 1'b1;
    #1;
    expect_out("rst.async", 8'h00, 8'h00, 8'h00, 8'h00); compare_out();
    @(negedge clk);
    reset = 1'b0;
    write_mask(8'hFF);
    pulse_irq(8'h01);
    expect_out("rst.resume", 8'h01, 8'h01, 8'h00, 8'hFF); compare_out();
    expect_out("rst.ack", 8'h00, 8'h01, 8'h01, 8'hFF);
    strobe(8'h01, 8'h00); compare_out();
`else
    // Level mode: pend follows the synchronised line, calli does not clear it.
    do_reset();
    write_mask(8'hFF);
    bus.irq = 8'h10;
    cycles(SYNC_STAGES + 1);
    expect_out("lvl.held", 8'h10, 8'h10, 8'h00, 8'hFF); compare_out();
    expect_out("lvl.ack", 8'h10, 8'h10, 8'h10, 8'hFF);
    strobe(8'h10, 8'h00); compare_out();
    cycles(HOLDOFF);
    expect_out("lvl.still", 8'h10, 8'h10, 8'h10, 8'hFF); compare_out();
    bus.irq = 8'h00;
    cycles(SYNC_STAGES + 1);
    expect_out("lvl.release", 8'h00, 8'h10, 8'h10, 8'hFF); compare_out();
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
